// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared constants and types for the instruction fetch stage
// Rev 1.0
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;

    // The ROM window starts at the reset vector.
    localparam logic [XLEN-1:0] C_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] C_ROM_LAST     = 32'hBFC0_0FFF;
    localparam logic [XLEN-1:0] C_NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            fault;
    } fd_t;

    localparam fd_t C_FD_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/fetch_decode_reg.sv
`default_nettype none
// ============================================================================
// fetch_decode_reg : F/D pipeline register with flush > stall > load priority
// Rev 1.0
// ============================================================================
module fetch_decode_reg
    import fetch_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic stall_i,
    input  fd_t  d_i,
    output fd_t  q_o
);

    fd_t r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= C_FD_BUBBLE;
        end else if (flush_i) begin
            r_q <= C_FD_BUBBLE;
        end else if (!stall_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC register, RUN/HALT fetch control and F/D register feed
// Rev 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR    = C_RESET_VECTOR,
    parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR = C_ROM_LAST
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic [DATA_WIDTH-1:0] instr_f_i,
    output logic [DATA_WIDTH-1:0] addr_f_o,
    output logic [DATA_WIDTH-1:0] instr_d_o,
    output logic [DATA_WIDTH-1:0] pc_d_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_d_o,
    output logic                  valid_d_o,
    output logic                  fault_d_o
);

    // Highest address at which a whole 4-byte word still fits in the ROM.
    localparam logic [DATA_WIDTH-1:0] C_LAST_WORD = LAST_INSTR_ADDR - DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] C_PC_STEP   = DATA_WIDTH'(4);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_fault;
    fd_t                   w_fd_d;
    fd_t                   w_fd_q;

    assign w_pc_plus4 = r_pc + C_PC_STEP;
    assign w_fault    = (r_pc[1:0] != 2'b00) || (r_pc < RESET_VECTOR) || (r_pc > C_LAST_WORD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fd_d      = C_FD_BUBBLE;

        if (r_state == RUN) begin
            w_fd_d.pc       = r_pc;
            w_fd_d.pc_plus4 = w_pc_plus4;
            w_fd_d.valid    = 1'b1;
            if (w_fault) begin
                // Faulting PC is reported once as a NOP and then held.
                w_fd_d.instr = C_NOP_INSTR;
                w_fd_d.fault = 1'b1;
                if (!redirect_i && !stall_i) begin
                    w_state_nxt = HALT;
                end
            end else begin
                w_fd_d.instr = instr_f_i;
                if (!stall_i) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
        end

        if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_state_nxt = RUN;
        end
    end

    fetch_decode_reg u_fd_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .stall_i (stall_i),
        .d_i     (w_fd_d),
        .q_o     (w_fd_q)
    );

    assign addr_f_o     = r_pc;
    assign instr_d_o    = w_fd_q.instr;
    assign pc_d_o       = w_fd_q.pc;
    assign pc_plus4_d_o = w_fd_q.pc_plus4;
    assign valid_d_o    = w_fd_q.valid;
    assign fault_d_o    = w_fd_q.fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed and randomized checks of fetch_unit against a model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] LAST = 32'hBFC0_0FFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_f;
    logic [31:0] addr_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        fault_d;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    bit          m_valid;
    bit          m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    assign instr_f = rom(addr_f);

    fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_f_i     (instr_f),
        .addr_f_o      (addr_f),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .pc_plus4_d_o  (pc4_d),
        .valid_d_o     (valid_d),
        .fault_d_o     (fault_d)
    );

    task automatic model_reset();
        m_pc = RV; m_halt = 0;
        m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
    endtask

    // One clock edge; the model advances from the inputs held across that edge.
    task automatic tick();
        bit          bad;
        logic [31:0] e_instr, e_pc, e_pc4, n_pc;
        bit          e_v, e_f, n_halt;
        bad = !m_halt && ((m_pc % 4) != 0 || m_pc < RV ||
                          ({32'd0, m_pc} + 64'd4 > {32'd0, LAST} + 64'd1));
        if (m_halt) begin
            e_instr = 0; e_pc = 0; e_pc4 = 0; e_v = 0; e_f = 0;
        end else begin
            e_instr = bad ? 32'd0 : rom(m_pc);
            e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_v = 1; e_f = bad;
        end
        if (redirect)                     n_pc = redirect_pc;
        else if (stall || m_halt || bad)  n_pc = m_pc;
        else                              n_pc = m_pc + 32'd4;
        if (redirect)                     n_halt = 0;
        else if (bad && !stall)           n_halt = 1;
        else                              n_halt = m_halt;
        @(posedge clk);
        #1;
        if (flush) begin
            m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
        end else if (!stall) begin
            m_instr = e_instr; m_pcd = e_pc; m_pc4 = e_pc4; m_valid = e_v; m_fault = e_f;
        end
        m_pc = n_pc;
        m_halt = n_halt;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        checks++; if (addr_f !== RV) begin errors++; $display("FAIL reset_pc: got %h want %h", addr_f, RV); end
        checks++; if ({valid_d, fault_d} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {valid_d, fault_d}); end
        checks++; if ({instr_d, pc_d, pc4_d} !== 96'd0) begin errors++; $display("FAIL reset_fd: got %h %h %h want zeros", instr_d, pc_d, pc4_d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (addr_f !== RV + 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, addr_f, RV + 32'(4 * i)); end
            checks++; if ({valid_d, fault_d, pc_d, instr_d} !== {2'b10, RV + 32'(4 * (i - 1)), rom(RV + 32'(4 * (i - 1)))}) begin
                errors++; $display("FAIL seq_fd%0d: got v%b f%b pc %h ins %h", i, valid_d, fault_d, pc_d, instr_d);
            end
        end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (addr_f !== 32'hBFC0_0010) begin errors++; $display("FAIL stall_pre: got %h want bfc00010", addr_f); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({addr_f, pc_d, instr_d, valid_d} !== {32'hBFC0_0010, 32'hBFC0_000C, rom(32'hBFC0_000C), 1'b1}) begin
                errors++; $display("FAIL stall_hold%0d: got pc %h pcd %h ins %h v%b", i, addr_f, pc_d, instr_d, valid_d);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if ({addr_f, pc_d} !== {32'hBFC0_0014, 32'hBFC0_0010}) begin errors++; $display("FAIL stall_release: got pc %h pcd %h want bfc00014 bfc00010", addr_f, pc_d); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hBFC0_0100;
        tick();
        stall = 1'b0; redirect = 1'b0;
        checks++; if (addr_f !== 32'hBFC0_0100) begin errors++; $display("FAIL redir_stall_pc: got %h want bfc00100", addr_f); end
        checks++; if ({pc_d, instr_d, valid_d} !== {32'hBFC0_0010, rom(32'hBFC0_0010), 1'b1}) begin
            errors++; $display("FAIL redir_stall_fd: got pcd %h ins %h v%b want bfc00010", pc_d, instr_d, valid_d);
        end
    endtask

    task automatic test_fault_halt();
        redirect = 1'b1; redirect_pc = 32'hBFC0_0102;
        tick();
        redirect = 1'b0;
        checks++; if ({addr_f, pc_d, valid_d, fault_d} !== {32'hBFC0_0102, 32'hBFC0_0100, 2'b10}) begin
            errors++; $display("FAIL delay_slot: got pc %h pcd %h v%b f%b", addr_f, pc_d, valid_d, fault_d);
        end
        tick();
        checks++; if ({fault_d, valid_d, instr_d, pc_d} !== {2'b11, 32'd0, 32'hBFC0_0102}) begin
            errors++; $display("FAIL misalign_fault: got f%b v%b ins %h pcd %h", fault_d, valid_d, instr_d, pc_d);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({addr_f, valid_d} !== {32'hBFC0_0102, 1'b0}) begin errors++; $display("FAIL halt_hold%0d: got pc %h v%b", i, addr_f, valid_d); end
        end
        redirect = 1'b1; redirect_pc = 32'hBFC0_0200;
        tick();
        redirect = 1'b0;
        checks++; if (addr_f !== 32'hBFC0_0200) begin errors++; $display("FAIL halt_redirect: got %h want bfc00200", addr_f); end
        tick();
        checks++; if ({addr_f, pc_d, instr_d, valid_d, fault_d} !== {32'hBFC0_0204, 32'hBFC0_0200, rom(32'hBFC0_0200), 2'b10}) begin
            errors++; $display("FAIL resume: got pc %h pcd %h ins %h v%b f%b", addr_f, pc_d, instr_d, valid_d, fault_d);
        end
    endtask

    task automatic test_rom_end();
        redirect = 1'b1; redirect_pc = 32'hBFC0_0FF8;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        checks++; if ({addr_f, pc_d, instr_d, valid_d, fault_d} !== {32'hBFC0_1000, 32'hBFC0_0FFC, rom(32'hBFC0_0FFC), 2'b10}) begin
            errors++; $display("FAIL last_word: got pc %h pcd %h ins %h v%b f%b", addr_f, pc_d, instr_d, valid_d, fault_d);
        end
        tick();
        checks++; if ({fault_d, valid_d, instr_d, pc_d} !== {2'b11, 32'd0, 32'hBFC0_1000}) begin
            errors++; $display("FAIL past_end_fault: got f%b v%b ins %h pcd %h", fault_d, valid_d, instr_d, pc_d);
        end
        tick();
        checks++; if ({addr_f, valid_d} !== {32'hBFC0_1000, 1'b0}) begin errors++; $display("FAIL past_end_halt: got pc %h v%b", addr_f, valid_d); end
    endtask

    task automatic test_flush_stall_reset();
        redirect = 1'b1; redirect_pc = 32'hBFC0_0300;
        tick();
        redirect = 1'b0;
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++; if ({valid_d, addr_f} !== {1'b0, 32'hBFC0_0304}) begin errors++; $display("FAIL flush_over_stall: got v%b pc %h", valid_d, addr_f); end
        redirect = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if ({fault_d, pc_d} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL low_fault: got f%b pcd %h", fault_d, pc_d); end
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if ({addr_f, valid_d, fault_d} !== {RV, 2'b00}) begin errors++; $display("FAIL halt_reset: got pc %h v%b f%b", addr_f, valid_d, fault_d); end
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        tick();
        checks++; if ({addr_f, pc_d, valid_d} !== {RV + 32'd4, RV, 1'b1}) begin errors++; $display("FAIL post_reset_run: got pc %h pcd %h v%b", addr_f, pc_d, valid_d); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       redirect_pc = RV + ($urandom_range(0, 4095) | 32'd1);
                1:       redirect_pc = $urandom_range(0, 32'h0FFF_FFFF);
                2:       redirect_pc = 32'hBFC0_0FF0 + 32'(4 * $urandom_range(0, 3));
                default: redirect_pc = RV + 32'(4 * $urandom_range(0, 1023));
            endcase
            tick();
            checks++; if (addr_f !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h want %h", i, addr_f, m_pc); end
            checks++; if ({instr_d, pc_d, pc4_d, valid_d, fault_d} !== {m_instr, m_pcd, m_pc4, m_valid, m_fault}) begin
                errors++;
                $display("FAIL rand_fd[%0d]: got %h %h %h v%b f%b want %h %h %h v%b f%b", i,
                         instr_d, pc_d, pc4_d, valid_d, fault_d, m_instr, m_pcd, m_pc4, m_valid, m_fault);
            end
        end
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_fault_halt();
        test_rom_end();
        test_flush_stall_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning first fetch address.
REQ-003 SHALL have parameter LAST_INSTR_ADDR, default 32'hBFC00FFF, meaning last valid ROM byte address.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall_i  input  1  decode cannot accept; hold PC and F/D register.
REQ-007 SHALL have port flush_i  input  1  invalidate F/D register next edge.
REQ-008 SHALL have port redirect_i  input  1  load redirect_pc_i into PC.
REQ-009 SHALL have port redirect_pc_i  input  32  branch/jump target.
REQ-010 SHALL have port instr_f_i  input  32  instruction word from the combinational instruction ROM.
REQ-011 SHALL have port addr_f_o  output  32  current PC, driven to the instruction ROM.
REQ-012 SHALL have ports instr_d_o, pc_d_o, pc_plus4_d_o  output  32 each  F/D register contents.
REQ-013 SHALL have port valid_d_o  output  1  F/D register holds a real instruction.
REQ-014 SHALL have port fault_d_o  output  1  F/D entry is a fetch fault (misaligned or out-of-range PC).

Function
REQ-015 SHALL keep PC in a 32-bit register; addr_f_o = PC combinationally, no other logic.
REQ-016 SHALL implement FSM states RUN and HALT; reset state RUN.
REQ-017 In RUN, a PC is faulty when PC[1:0] != 0, PC < RESET_VECTOR, or PC > LAST_INSTR_ADDR-3.
REQ-018 Next-PC priority: redirect_i > stall_i (hold) > fault (hold) > PC+4, modulo 2^32.
REQ-019 redirect_i SHALL load PC even while stall_i is high, in either state, and moves HALT->RUN.
REQ-020 RUN->HALT when the PC is faulty, stall_i=0 and redirect_i=0; fault entry captured in F/D that edge.
REQ-021 In HALT without redirect_i, PC SHALL hold and F/D SHALL load a bubble (valid_d_o=0) unless stalled.
REQ-022 F/D update priority: flush_i > stall_i (hold) > load; flush wins over stall in the same cycle.
REQ-023 F/D load in RUN, non-faulty: instr_d_o=instr_f_i, pc_d_o=PC, pc_plus4_d_o=PC+4, valid=1, fault=0.
REQ-024 F/D load on fault: instr_d_o=32'h0 (NOP), pc_d_o=PC, valid=1, fault=1.
REQ-025 redirect_i without flush_i SHALL load the current fetch into F/D normally (delay-slot semantics).
REQ-026 Latency: instruction at PC appears on instr_d_o one edge after PC is presented.

Reset
REQ-027 On rst_ni low, asynchronously: PC=RESET_VECTOR, state=RUN, valid_d_o=0, fault_d_o=0, instr_d_o=0, pc_d_o=0, pc_plus4_d_o=0.
REQ-028 Reset asserted mid-stall or in HALT SHALL override all inputs; first fetch after release is RESET_VECTOR.

Structure
REQ-029 Package fetch_pkg SHALL hold RESET_VECTOR, ROM bounds, NOP_INSTR, the RUN/HALT enum and the F/D struct typedef.
REQ-030 F/D register SHALL be sub-module fetch_decode_reg (flush/stall/load, async active-low reset); PC and FSM stay in fetch_unit.

Verification
REQ-031 Reset release, no stall: addr_f_o = BFC00000, BFC00004, BFC00008 on successive edges; valid_d_o=1 from edge 1.
REQ-032 stall_i high 3 cycles at PC=BFC00010: PC and F/D frozen; release -> BFC00014 next edge.
REQ-033 redirect_i=1, redirect_pc_i=BFC00100 with stall_i=1: PC=BFC00100 next edge; F/D unchanged.
REQ-034 redirect_pc_i=BFC00102: next edge fault_d_o=1, instr_d_o=0, state HALT; PC holds until redirect BFC00200 resumes fetch.
REQ-035 Sequential run reaching BFC00FFC: fetched normally; next PC BFC01000 -> fault_d_o=1, HALT.
REQ-036 flush_i and stall_i together: valid_d_o=0 next edge; rst_ni pulsed mid-HALT -> PC=BFC00000, RUN.
